// File: rtl/multi_mode_shift_sequencer.sv
// Multi-cycle shift unit: loads an operand, then shifts it one bit per clock
// for a saturated programmable count in one of four modes, with
// start/busy/done handshake, hold (pause) and carry-out.
module multi_mode_shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CNT_W-1:0] amount,
  input  logic [1:0]       mode,
  input  logic             hold,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ARITH_R = 2'b00,
    LOGIC_R = 2'b01,
    LOGIC_L = 2'b10,
    ROTATE_R = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state, state_nxt;
  mode_t            mode_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] amt_sat;
  logic [WIDTH-1:0] shifted;
  logic             shift_carry;

  // Requested count clamped to WIDTH (unsigned compare)
  always_comb begin
    amt_sat = amount;
    if (amount > MAX_CNT) amt_sat = MAX_CNT;
  end

  // One-bit shift of the current contents under the latched mode
  always_comb begin
    shifted     = out;
    shift_carry = 1'b0;
    case (mode_q)
      ARITH_R: begin
        shifted     = {out[WIDTH-1], out[WIDTH-1:1]};
        shift_carry = out[0];
      end
      LOGIC_R: begin
        shifted     = {1'b0, out[WIDTH-1:1]};
        shift_carry = out[0];
      end
      LOGIC_L: begin
        shifted     = {out[WIDTH-2:0], 1'b0};
        shift_carry = out[WIDTH-1];
      end
      ROTATE_R: begin
        shifted     = {out[0], out[WIDTH-1:1]};
        shift_carry = out[0];
      end
      default: begin
        shifted     = out;
        shift_carry = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (amt_sat == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (!hold && count == ONE_CNT) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, carry, count and mode registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out    <= '0;
      carry  <= 1'b0;
      count  <= '0;
      mode_q <= ARITH_R;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            out    <= load_val;
            carry  <= 1'b0;
            count  <= amt_sat;
            mode_q <= mode_t'(mode);
          end
        end
        SHIFT: begin
          if (!hold) begin
            out   <= shifted;
            carry <= shift_carry;
            count <= count - ONE_CNT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_mode_shift_sequencer.sv
// Self-checking bench for multi_mode_shift_sequencer (WIDTH=16): a table of
// operations plus hand-written hold/abort sequences, with expected results
// queued at issue and compared when done is seen.
module tb_multi_mode_shift_sequencer;

  localparam int W     = 16;
  localparam int CW    = 5;
  localparam int LIMIT = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  load_val;
  logic [CW-1:0] amount;
  logic [1:0]    mode;
  logic          hold;
  logic [W-1:0]  out;
  logic          carry;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0]  lv;
    logic [CW-1:0] amt;
    logic [1:0]    md;
    logic [W-1:0]  eo;
    logic          ec;
    int            ebusy;
    int            edone;
  } vec_t;

  typedef struct {
    logic [W-1:0] eo;
    logic         ec;
    int           ebusy;
    int           edone;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];

  multi_mode_shift_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load_val (load_val),
    .amount   (amount),
    .mode     (mode),
    .hold     (hold),
    .out      (out),
    .carry    (carry),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Issue one operation at the current negedge (DUT must be in IDLE), then
  // follow it to done. hs/hn: hold during cycles hs..hs+hn-1 after the load.
  // poke: flip mode mid-shift and pulse start while busy.
  task automatic run_op(input string tag, input logic [W-1:0] lv, input logic [CW-1:0] amt,
                        input logic [1:0] md, input logic [W-1:0] eo, input logic ec,
                        input int ebusy, input int edone, input int hs, input int hn,
                        input bit poke);
    int   cyc;
    int   busy_cnt;
    exp_t e;
    sb.push_back('{eo, ec, ebusy, edone});
    start    = 1'b1;
    load_val = lv;
    amount   = amt;
    mode     = md;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (busy === 1'b1) busy_cnt++;
      hold = (cyc >= hs && cyc < hs + hn);
      if (poke && cyc == 2) mode = ~md;
      if (poke && cyc == 6) begin
        start    = 1'b1;
        load_val = 16'hDEAD;
        amount   = 5'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    hold  = 1'b0;
    start = 1'b0;
    e = sb.pop_front();
    if (done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, LIMIT);
      return;
    end
    chk({tag, " out"},        32'(out),      32'(e.eo));
    chk({tag, " carry"},      32'(carry),    32'(e.ec));
    chk({tag, " done_cycle"}, 32'(cyc),      32'(e.edone));
    chk({tag, " busy_cycles"},32'(busy_cnt), 32'(e.ebusy));
    chk({tag, " busy_at_done"}, 32'(busy),   32'd0);
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done),     32'd0);
    chk({tag, " out_held"},   32'(out),      32'(e.eo));
  endtask

  initial begin
    vecs[0]  = '{16'h8000, 5'd1,  2'b00, 16'hC000, 1'b0, 1,  2};
    vecs[1]  = '{16'h8001, 5'd4,  2'b01, 16'h0800, 1'b0, 4,  5};
    vecs[2]  = '{16'h0001, 5'd1,  2'b11, 16'h8000, 1'b1, 1,  2};
    vecs[3]  = '{16'h0001, 5'd16, 2'b11, 16'h0001, 1'b0, 16, 17};
    vecs[4]  = '{16'hFFFF, 5'd20, 2'b10, 16'h0000, 1'b1, 16, 17};
    vecs[5]  = '{16'h8000, 5'd16, 2'b00, 16'hFFFF, 1'b1, 16, 17};
    vecs[6]  = '{16'hA5A5, 5'd16, 2'b01, 16'h0000, 1'b1, 16, 17};
    vecs[7]  = '{16'h1234, 5'd0,  2'b00, 16'h1234, 1'b0, 0,  1};
    vecs[8]  = '{16'h7FFF, 5'd3,  2'b00, 16'h0FFF, 1'b1, 3,  4};
    vecs[9]  = '{16'h00F0, 5'd4,  2'b10, 16'h0F00, 1'b0, 4,  5};
    vecs[10] = '{16'h1234, 5'd31, 2'b11, 16'h1234, 1'b0, 16, 17};
    vecs[11] = '{16'h8001, 5'd17, 2'b01, 16'h0000, 1'b1, 16, 17};
    vecs[12] = '{16'h8001, 5'd5,  2'b00, 16'hFC00, 1'b0, 5,  6};

    rst_n    = 1'b0;
    start    = 1'b0;
    load_val = '0;
    amount   = '0;
    mode     = 2'b00;
    hold     = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset out",   32'(out),   32'd0);
    chk("reset carry", 32'(carry), 32'd0);
    chk("reset busy",  32'(busy),  32'd0);
    chk("reset done",  32'(done),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: operations issued back to back (start in the cycle after DONE)
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].lv, vecs[i].amt, vecs[i].md,
             vecs[i].eo, vecs[i].ec, vecs[i].ebusy, vecs[i].edone, 0, 0, 1'b0);
    end

    // Hold for 3 mid-shift cycles, mode flip and stray start while busy:
    // same result as vec12, done 3 cycles later
    run_op("hold5", 16'h8001, 5'd5, 2'b00, 16'hFC00, 1'b0, 8, 9, 2, 3, 1'b1);

    // Abort mid-shift with reset
    start    = 1'b1;
    load_val = 16'hFFFF;
    amount   = 5'd8;
    mode     = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort busy",  32'(busy),  32'd1);
    chk("pre_abort carry", 32'(carry), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort out",   32'(out),   32'd0);
    chk("abort carry", 32'(carry), 32'd0);
    chk("abort busy",  32'(busy),  32'd0);
    chk("abort done",  32'(done),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_abort", 16'h1234, 5'd0, 2'b00, 16'h1234, 1'b0, 0, 1, 0, 0, 1'b0);

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
